// File: rtl/pcap_replay_pkg.sv
// Shared sizing for the pcap replay path: lane ratio, lane-count width and
// FIFO count width, plus helpers that derive them for any parameter set.
package pcap_replay_pkg;

   function automatic int calc_ratio(input int out_w, input int in_w);
      return out_w / in_w;
   endfunction

   function automatic int calc_lane_width(input int ratio);
      return $clog2(ratio) + 1;
   endfunction

   function automatic int calc_count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   localparam int DEF_IN_DATA_WIDTH  = 64;
   localparam int DEF_OUT_DATA_WIDTH = 256;
   localparam int DEF_DEPTH          = 16;

   localparam int RATIO  = calc_ratio(DEF_OUT_DATA_WIDTH, DEF_IN_DATA_WIDTH);
   localparam int LANE_W = calc_lane_width(RATIO);
   localparam int CNT_W  = calc_count_width(DEF_DEPTH);

endpackage

// File: rtl/pcap_pack_fifo_ram.sv
// Entry storage for pcap_pack_fifo: synchronous write, asynchronous read.
module pcap_pack_fifo_ram #(
   parameter int DATA_WIDTH = 259,
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];

   // Write port
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata = mem_r[raddr];

endmodule

// File: rtl/pcap_pack_fifo.sv
// Narrow-to-wide packing FIFO: gathers RATIO input words (MSB lane first) into
// one entry, closing early on din_last, and presents the head entry FWFT.
module pcap_pack_fifo
   import pcap_replay_pkg::*;
#(
   parameter int IN_DATA_WIDTH  = DEF_IN_DATA_WIDTH,
   parameter int OUT_DATA_WIDTH = DEF_OUT_DATA_WIDTH,
   parameter int DEPTH          = DEF_DEPTH,
   localparam int RATIO_L  = calc_ratio(OUT_DATA_WIDTH, IN_DATA_WIDTH),
   localparam int LANE_W_L = calc_lane_width(RATIO_L)
) (
   input  logic                      axi_aclk,
   input  logic                      axi_resetn,
   input  logic                      wr_en,
   input  logic [IN_DATA_WIDTH-1:0]  din,
   input  logic                      din_last,
   output logic                      full,
   output logic                      almost_full,
   input  logic                      rd_en,
   output logic [OUT_DATA_WIDTH-1:0] dout,
   output logic [LANE_W_L-1:0]       dout_lanes,
   output logic                      empty,
   output logic                      almost_empty
);

   localparam int CNT_W_L = calc_count_width(DEPTH);
   localparam int PTR_W   = $clog2(DEPTH);
   localparam int LIDX_W  = $clog2(RATIO_L);
   localparam int ENT_W   = OUT_DATA_WIDTH + LANE_W_L;

   logic [OUT_DATA_WIDTH-1:0] acc_r;
   logic [LIDX_W-1:0]         lane_r;
   logic [CNT_W_L-1:0]        count_r;
   logic [PTR_W-1:0]          wr_ptr_r;
   logic [PTR_W-1:0]          rd_ptr_r;
   logic                      full_r;
   logic                      almost_full_r;
   logic                      empty_r;
   logic                      almost_empty_r;
   logic [OUT_DATA_WIDTH-1:0] dout_r;
   logic [LANE_W_L-1:0]       lanes_r;

   logic                      accept_s;
   logic                      complete_s;
   logic                      push_s;
   logic                      pop_s;
   logic [OUT_DATA_WIDTH-1:0] lane_word_s;
   logic [OUT_DATA_WIDTH-1:0] acc_fill_s;
   logic [LANE_W_L-1:0]       wr_lanes_s;
   logic [ENT_W-1:0]          wr_entry_s;
   logic [ENT_W-1:0]          rd_entry_s;
   logic [ENT_W-1:0]          head_next_s;
   logic [CNT_W_L-1:0]        count_next_s;
   logic [PTR_W-1:0]          rd_ptr_next_s;

   // Pack datapath and push/pop decisions
   always_comb begin
      accept_s    = wr_en && !full_r;
      complete_s  = din_last || (lane_r == LIDX_W'(RATIO_L - 1));
      push_s      = accept_s && complete_s;
      pop_s       = rd_en && !empty_r;
      lane_word_s = {din, {(OUT_DATA_WIDTH - IN_DATA_WIDTH){1'b0}}}
                    >> (int'(lane_r) * IN_DATA_WIDTH);
      acc_fill_s  = acc_r | lane_word_s;
      wr_lanes_s  = {1'b0, lane_r} + LANE_W_L'(1);
      wr_entry_s  = {acc_fill_s, wr_lanes_s};
   end

   // Next occupancy, read pointer and head entry
   always_comb begin
      case ({push_s, pop_s})
         2'b10:   count_next_s = count_r + CNT_W_L'(1);
         2'b01:   count_next_s = count_r - CNT_W_L'(1);
         default: count_next_s = count_r;
      endcase
      if (pop_s) begin
         rd_ptr_next_s = rd_ptr_r + PTR_W'(1);
      end else begin
         rd_ptr_next_s = rd_ptr_r;
      end
      // The new head may be the very entry being written this cycle.
      if (count_next_s == CNT_W_L'(0)) begin
         head_next_s = {dout_r, lanes_r};
      end else if (push_s && (wr_ptr_r == rd_ptr_next_s)) begin
         head_next_s = wr_entry_s;
      end else begin
         head_next_s = rd_entry_s;
      end
   end

   // Accumulator, lane counter, pointers and count
   always_ff @(posedge axi_aclk) begin
      if (!axi_resetn) begin
         acc_r    <= {OUT_DATA_WIDTH{1'b0}};
         lane_r   <= {LIDX_W{1'b0}};
         count_r  <= {CNT_W_L{1'b0}};
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
      end else begin
         count_r  <= count_next_s;
         rd_ptr_r <= rd_ptr_next_s;
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (accept_s) begin
            if (complete_s) begin
               acc_r  <= {OUT_DATA_WIDTH{1'b0}};
               lane_r <= {LIDX_W{1'b0}};
            end else begin
               acc_r  <= acc_fill_s;
               lane_r <= lane_r + LIDX_W'(1);
            end
         end
      end
   end

   // Registered flags and head presentation
   always_ff @(posedge axi_aclk) begin
      if (!axi_resetn) begin
         full_r         <= 1'b0;
         almost_full_r  <= 1'b0;
         empty_r        <= 1'b1;
         almost_empty_r <= 1'b1;
         dout_r         <= {OUT_DATA_WIDTH{1'b0}};
         lanes_r        <= {LANE_W_L{1'b0}};
      end else begin
         full_r         <= (count_next_s == CNT_W_L'(DEPTH));
         almost_full_r  <= (count_next_s >= CNT_W_L'(DEPTH - 1));
         empty_r        <= (count_next_s == CNT_W_L'(0));
         almost_empty_r <= (count_next_s <= CNT_W_L'(1));
         dout_r         <= head_next_s[ENT_W-1 -: OUT_DATA_WIDTH];
         lanes_r        <= head_next_s[LANE_W_L-1:0];
      end
   end

   pcap_pack_fifo_ram #(
      .DATA_WIDTH (ENT_W),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (PTR_W)
   ) u_ram (
      .clk   (axi_aclk),
      .we    (push_s && axi_resetn),
      .waddr (wr_ptr_r),
      .wdata (wr_entry_s),
      .raddr (rd_ptr_next_s),
      .rdata (rd_entry_s)
   );

   assign full         = full_r;
   assign almost_full  = almost_full_r;
   assign empty        = empty_r;
   assign almost_empty = almost_empty_r;
   assign dout         = dout_r;
   assign dout_lanes   = lanes_r;

endmodule

// File: doc/pcap_pack_fifo.md
PCAP_PACK_FIFO -- requirements
Module: pcap_pack_fifo

Interface
REQ-001 SHALL have parameter IN_DATA_WIDTH, default 64, meaning the width of each write word.
REQ-002 SHALL have parameter OUT_DATA_WIDTH, default 256, meaning the width of each read word; it must be an integer multiple RATIO = OUT_DATA_WIDTH/IN_DATA_WIDTH ≥ 2.
REQ-003 SHALL have parameter DEPTH, default 16, meaning the number of OUT_DATA_WIDTH entries stored; it must be a power of two ≥ 4.
REQ-004 SHALL have one clock and a synchronous, active-low reset: axi_aclk is the single clock, axi_resetn is the reset, and all logic samples on the rising edge of axi_aclk.
REQ-005 axi_aclk  in  1  clock.
REQ-006 axi_resetn  in  1  synchronous active-low reset.
REQ-007 wr_en  in  1  write strobe for din.
REQ-008 din  in  IN_DATA_WIDTH  narrow write word.
REQ-009 din_last  in  1  qualified by wr_en; closes the current packed word early.
REQ-010 full  out  1  writes are ignored while this is high.
REQ-011 almost_full  out  1  storage count ≥ DEPTH-1.
REQ-012 rd_en  in  1  pops the head entry.
REQ-013 dout  out  OUT_DATA_WIDTH  head entry, first-word-fall-through.
REQ-014 dout_lanes  out  clog2(RATIO)+1  number of valid lanes in dout, from 1 to RATIO.
REQ-015 empty  out  1  no entry is stored.
REQ-016 almost_empty  out  1  storage count ≤ 1.

Function
REQ-017 SHALL pack RATIO accepted writes into one entry; the first write goes to the MSB lane, dout[OUT-1 -: IN], and later writes go to successively lower lanes.
REQ-018 A write is accepted when wr_en=1 and full=0; a write with full=1 SHALL be dropped with no state change, even if rd_en=1 in the same cycle.
REQ-019 An accumulator with a lane counter (0..RATIO-1) SHALL complete an entry when an accepted write fills lane RATIO-1, or when the write has din_last=1.
REQ-020 On an early completion, unfilled lower lanes SHALL be zero, dout_lanes SHALL equal the number of filled lanes, and the lane counter SHALL return to 0.
REQ-021 A completed entry SHALL appear in storage the cycle after the completing write: count increments and empty falls on the next edge.
REQ-022 full SHALL be 1 exactly when count == DEPTH; it is derived only from the registered count.
REQ-023 While !empty, dout and dout_lanes SHALL present the head entry; rd_en=1 pops it, and the next entry (or empty=1) appears on the following cycle.
REQ-024 rd_en while empty SHALL be ignored (no underflow, count stays 0); dout holds its last value.
REQ-025 A push and a pop in the same cycle SHALL leave count unchanged and keep data in order.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH; count width is clog2(DEPTH+1).
REQ-027 The accumulator SHALL not change while full=1.

Reset
REQ-028 While axi_resetn=0 at an edge, the block SHALL clear: count=0, pointers=0, lane counter=0, accumulator=0.
REQ-029 Reset outputs SHALL be: empty=1, almost_empty=1, full=0, almost_full=0, dout=0, dout_lanes=0.
REQ-030 A reset mid-packet SHALL discard the partial accumulator and all stored entries; a write in the reset cycle SHALL be ignored.

Structure
REQ-031 RATIO, the lane-count width, and the count width SHALL be localparams in shared package pcap_replay_pkg.
REQ-032 Storage SHALL be one sub-module, pcap_pack_fifo_ram: DEPTH × (OUT_DATA_WIDTH + lane-count width), synchronous write, asynchronous read.
REQ-033 Pack logic, pointers, and flags SHALL live in the top-level module.

Verification
REQ-034 Write 1,2,3,4 (64-bit) -> 1 cycle later empty=0, dout=0x…0001_…0002_…0003_…0004 (MSB lane first), dout_lanes=4.
REQ-035 Write 0xA,0xB with din_last on 0xB -> dout = {0xA,0xB,0,0}, dout_lanes=2; a following write starts in the MSB lane.
REQ-036 Write 64 words without reads -> full=1 after the 16th entry and almost_full=1 at 15; the 65th write is dropped; then 16 pops return all entries in order and empty=1 after the last.
REQ-037 With count=16, assert wr_en and rd_en together -> the write is dropped and count=15; with count=5, complete a push while popping -> count stays 5.
REQ-038 Assert rd_en while empty -> empty stays 1 and count stays 0; write 3 words, pulse axi_resetn=0 for 1 cycle, then write 4 words -> exactly one entry appears, containing only the new 4 words.
REQ-039 Run random wr_en/rd_en at 50% for 10,000 cycles with mixed din_last against a scoreboard -> no mismatch, no overflow, no underflow.
